ps2_key_controller: RTL and testbench
=====================================

// Module: ps2_key_controller
// PURPOSE
// - Sequences PS/2 keyboard reception entirely in the system clock domain: sync + glitch-filter PS2_CLK/PS2_DAT,
//   frame FSM (start/8 data/parity/stop), watchdog, then scan-code decoder (E0/F0 prefixes) and held-key flags.
// - Sits between the keyboard pins and game/control logic; replaces PS2_CLK-edge-clocked capture with one clock.
// PARAMETERS
// - SYNC_STAGES     2      flops in each input synchroniser (>=2)
// - FILTER_LEN      8      consecutive equal PS2_CLK samples required before filtered clock changes
// - TIMEOUT_CYCLES  10000  max CLK cycles between PS2 falling edges inside a frame (200 us @ 50 MHz)
// PORTS
// - CLK            in   1  system clock; all state on rising edge
// - RST_N          in   1  asynchronous active-low reset
// - PS2_CLK        in   1  raw keyboard clock, asynchronous, idle high
// - PS2_DAT        in   1  raw keyboard data, asynchronous, idle high
// - RX_DATA        out  8  last good frame byte; holds until next good frame
// - RX_VALID       out  1  one-cycle pulse, RX_DATA updated same cycle
// - RX_ERR         out  1  one-cycle pulse: parity, stop-bit or timeout error
// - SCAN_CODE      out  8  code byte of last key event (prefixes stripped)
// - KEY_EVENT      out  1  one-cycle pulse, SCAN_CODE/KEY_BREAK/KEY_EXT valid same cycle
// - KEY_BREAK      out  1  1 = release event (F0 seen), 0 = make
// - KEY_EXT        out  1  1 = extended event (E0 seen)
// - KEYPRESS_SPACE out  1  held flag, code 8'h29
// - KEYPRESS_W     out  1  held flag, code 8'h1D
// - KEYPRESS_S     out  1  held flag, code 8'h1B
// - KEYPRESS_ESC   out  1  held flag, code 8'h76
// BEHAVIOUR
// - Reset (async assert, sync release via RST_N): all outputs 0; sync flops and filter shift reg all 1s;
//   filtered clock 1; both FSMs IDLE; watchdog 0; prefix flags 0. Reset mid-frame discards the partial byte.
// - Filter: filtered clock toggles only when last FILTER_LEN synced samples all differ from it. Falling edge = 1->0.
//   PS2_DAT sampled (synced) in the cycle the falling edge is detected.
// - Frame FSM states IDLE, DATA, PARITY, STOP:
//   IDLE  : edge with DAT=0 -> DATA, bitcnt=0; edge with DAT=1 ignored (stays IDLE, no error).
//   DATA  : each edge shifts DAT in LSB first; after 8th bit -> PARITY.
//   PARITY: sample parity bit -> STOP.
//   STOP  : on edge: stop=1 and odd parity over 9 bits -> RX_VALID pulse next cycle, RX_DATA loaded;
//           otherwise RX_ERR pulse next cycle, RX_DATA unchanged. Always -> IDLE.
// - Watchdog: cleared on every falling edge; counts while FSM != IDLE; at TIMEOUT_CYCLES-1 -> RX_ERR pulse,
//   FSM -> IDLE, partial byte dropped. Held at 0 in IDLE. RX_VALID and RX_ERR never assert in the same cycle.
// - Decoder (acts on RX_VALID; KEY_EVENT one cycle after RX_VALID):
//   8'hE0 -> ext=1; 8'hF0 -> brk=1 (either order, no event); 8'h00 ignored, prefixes kept;
//   any other byte -> KEY_EVENT, SCAN_CODE=byte, KEY_BREAK=brk, KEY_EXT=ext; brk,ext cleared.
//   RX_ERR clears brk and ext.
// - Held flags update in the KEY_EVENT cycle, only for ext=0 events of their code: make sets, break clears.
//   Extended events never affect held flags. Repeated makes (typematic) keep the flag set, one KEY_EVENT each.
// - Total latency: stop-bit edge at filter output -> RX_VALID +1 cycle -> KEY_EVENT/flags +1 cycle.
// STRUCTURE
// - Package ps2_pkg: scan-code constants (PS2_EXT=8'hE0, PS2_BRK=8'hF0, codes 29/1D/1B/76),
//   frame state enum {IDLE,DATA,PARITY,STOP}.
// - Sub-module ps2_frame_rx: sync, filter, frame FSM, watchdog; outputs RX_DATA/RX_VALID/RX_ERR.
//   Top instantiates it and implements the decoder and held flags.
// TESTING
// - Frame 8'h29 odd parity OK -> RX_VALID once, RX_DATA=8'h29, KEY_EVENT SCAN_CODE=29 BREAK=0 EXT=0, SPACE=1.
// - Stream F0,29 -> one KEY_EVENT SCAN_CODE=29 BREAK=1, SPACE=0; F0 alone yields no KEY_EVENT.
// - Stream E0,F0,75 -> KEY_EVENT SCAN_CODE=75 BREAK=1 EXT=1; E0,1D -> EXT=1, KEYPRESS_W unchanged.
// - 8'h1B with bad parity -> RX_ERR one pulse, no RX_VALID, KEYPRESS_S stays 0; stop bit 0 -> same.
// - 5 data bits then PS2_CLK held high > TIMEOUT_CYCLES -> RX_ERR pulse, IDLE; next good 8'h76 -> ESC=1.
// - 2-cycle PS2_CLK glitches (< FILTER_LEN) mid-frame -> ignored, byte correct; RST_N low mid-frame -> all 0.

Source files
------------

// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 scan-code constants and frame state encoding
package ps2_pkg;

    localparam logic [7:0] PS2_EXT   = 8'hE0;
    localparam logic [7:0] PS2_BRK   = 8'hF0;
    localparam logic [7:0] PS2_NUL   = 8'h00;
    localparam logic [7:0] PS2_SPACE = 8'h29;
    localparam logic [7:0] PS2_W     = 8'h1D;
    localparam logic [7:0] PS2_S     = 8'h1B;
    localparam logic [7:0] PS2_ESC   = 8'h76;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } frame_state_e;

endpackage

// File: rtl/ps2_frame_rx.sv
// rtl/ps2_frame_rx.sv - PS/2 pin synchroniser, clock glitch filter, frame FSM and watchdog
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] dat_sync_q, dat_sync_d;
    logic [FILTER_LEN-1:0]  filt_sh_q, filt_sh_d;
    logic                   filt_clk_q, filt_clk_d;
    frame_state_e           state_q, state_d;
    logic [2:0]             bitcnt_q, bitcnt_d;
    logic [7:0]             shift_q, shift_d;
    logic                   par_q, par_d;
    logic [WD_W-1:0]        wd_q, wd_d;
    logic [7:0]             rx_data_q, rx_data_d;
    logic                   rx_valid_q, rx_valid_d;
    logic                   rx_err_q, rx_err_d;

    logic clk_s, dat_s, fall;

    always_comb begin
        clk_sync_d = {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
        dat_sync_d = {dat_sync_q[SYNC_STAGES-2:0], ps2_dat};
        clk_s      = clk_sync_q[SYNC_STAGES-1];
        dat_s      = dat_sync_q[SYNC_STAGES-1];
        filt_sh_d  = {filt_sh_q[FILTER_LEN-2:0], clk_s};

        // The filtered clock only moves once the whole sample window disagrees with it.
        fall       = filt_clk_q && (filt_sh_q == '0);
        filt_clk_d = filt_clk_q;
        if (fall) begin
            filt_clk_d = 1'b0;
        end else if (!filt_clk_q && (&filt_sh_q)) begin
            filt_clk_d = 1'b1;
        end

        state_d    = state_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        par_d      = par_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_err_d   = 1'b0;
        wd_d       = (fall || state_q == IDLE) ? '0 : wd_q + 1'b1;

        case (state_q)
            IDLE: begin
                if (fall && !dat_s) begin
                    state_d  = DATA;
                    bitcnt_d = 3'd0;
                end
            end
            DATA: begin
                if (fall) begin
                    shift_d  = {dat_s, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (fall) begin
                    par_d   = dat_s;
                    state_d = STOP;
                end
            end
            STOP: begin
                if (fall) begin
                    if (dat_s && (^{shift_q, par_q})) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = shift_q;
                    end else begin
                        rx_err_d = 1'b1;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A falling edge clears the watchdog, so this never collides with the STOP outcome.
        if (state_q != IDLE && !fall && wd_q == WD_LAST) begin
            state_d  = IDLE;
            rx_err_d = 1'b1;
            wd_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync_q <= '1;
            dat_sync_q <= '1;
            filt_sh_q  <= '1;
            filt_clk_q <= 1'b1;
            state_q    <= IDLE;
            bitcnt_q   <= '0;
            shift_q    <= '0;
            par_q      <= 1'b0;
            wd_q       <= '0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_err_q   <= 1'b0;
        end else begin
            clk_sync_q <= clk_sync_d;
            dat_sync_q <= dat_sync_d;
            filt_sh_q  <= filt_sh_d;
            filt_clk_q <= filt_clk_d;
            state_q    <= state_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            par_q      <= par_d;
            wd_q       <= wd_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_err_q   <= rx_err_d;
        end
    end

    assign rx_data  = rx_data_q;
    assign rx_valid = rx_valid_q;
    assign rx_err   = rx_err_q;

endmodule

// File: rtl/ps2_key_controller.sv
// rtl/ps2_key_controller.sv - PS/2 keyboard receiver with E0/F0 decoding and held-key flags
module ps2_key_controller
    import ps2_pkg::*;
#(
    parameter int SYNC_STAGES    = 2,
    parameter int FILTER_LEN     = 8,
    parameter int TIMEOUT_CYCLES = 10000
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    output logic [7:0] RX_DATA,
    output logic       RX_VALID,
    output logic       RX_ERR,
    output logic [7:0] SCAN_CODE,
    output logic       KEY_EVENT,
    output logic       KEY_BREAK,
    output logic       KEY_EXT,
    output logic       KEYPRESS_SPACE,
    output logic       KEYPRESS_W,
    output logic       KEYPRESS_S,
    output logic       KEYPRESS_ESC
);

    logic [7:0] rx_data;
    logic       rx_valid, rx_err;

    ps2_frame_rx #(
        .SYNC_STAGES   (SYNC_STAGES),
        .FILTER_LEN    (FILTER_LEN),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_frame_rx (
        .clk     (CLK),
        .rst_n   (RST_N),
        .ps2_clk (PS2_CLK),
        .ps2_dat (PS2_DAT),
        .rx_data (rx_data),
        .rx_valid(rx_valid),
        .rx_err  (rx_err)
    );

    logic       ext_q, ext_d;
    logic       brk_q, brk_d;
    logic [7:0] scan_q, scan_d;
    logic       key_event_q, key_event_d;
    logic       key_break_q, key_break_d;
    logic       key_ext_q, key_ext_d;
    logic       space_q, space_d;
    logic       w_q, w_d;
    logic       s_q, s_d;
    logic       esc_q, esc_d;

    always_comb begin
        ext_d       = ext_q;
        brk_d       = brk_q;
        scan_d      = scan_q;
        key_event_d = 1'b0;
        key_break_d = key_break_q;
        key_ext_d   = key_ext_q;
        space_d     = space_q;
        w_d         = w_q;
        s_d         = s_q;
        esc_d       = esc_q;

        if (rx_err) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (rx_valid) begin
            if (rx_data == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (rx_data == PS2_BRK) begin
                brk_d = 1'b1;
            end else if (rx_data != PS2_NUL) begin
                key_event_d = 1'b1;
                scan_d      = rx_data;
                key_break_d = brk_q;
                key_ext_d   = ext_q;
                ext_d       = 1'b0;
                brk_d       = 1'b0;
                // Extended keys share codes with the base set, so they must not touch held flags.
                if (!ext_q) begin
                    if (rx_data == PS2_SPACE) space_d = !brk_q;
                    if (rx_data == PS2_W)     w_d     = !brk_q;
                    if (rx_data == PS2_S)     s_d     = !brk_q;
                    if (rx_data == PS2_ESC)   esc_d   = !brk_q;
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            scan_q      <= '0;
            key_event_q <= 1'b0;
            key_break_q <= 1'b0;
            key_ext_q   <= 1'b0;
            space_q     <= 1'b0;
            w_q         <= 1'b0;
            s_q         <= 1'b0;
            esc_q       <= 1'b0;
        end else begin
            ext_q       <= ext_d;
            brk_q       <= brk_d;
            scan_q      <= scan_d;
            key_event_q <= key_event_d;
            key_break_q <= key_break_d;
            key_ext_q   <= key_ext_d;
            space_q     <= space_d;
            w_q         <= w_d;
            s_q         <= s_d;
            esc_q       <= esc_d;
        end
    end

    assign RX_DATA        = rx_data;
    assign RX_VALID       = rx_valid;
    assign RX_ERR         = rx_err;
    assign SCAN_CODE      = scan_q;
    assign KEY_EVENT      = key_event_q;
    assign KEY_BREAK      = key_break_q;
    assign KEY_EXT        = key_ext_q;
    assign KEYPRESS_SPACE = space_q;
    assign KEYPRESS_W     = w_q;
    assign KEYPRESS_S     = s_q;
    assign KEYPRESS_ESC   = esc_q;

endmodule

// File: tb/tb_ps2_key_controller.sv
// tb/tb_ps2_key_controller.sv - self-checking bench for ps2_key_controller
module tb_ps2_key_controller;

    localparam int HP  = 20;
    localparam int TMO = 200;

    logic       CLK = 1'b0;
    logic       RST_N, PS2_CLK, PS2_DAT;
    logic [7:0] RX_DATA, SCAN_CODE;
    logic       RX_VALID, RX_ERR, KEY_EVENT, KEY_BREAK, KEY_EXT;
    logic       KEYPRESS_SPACE, KEYPRESS_W, KEYPRESS_S, KEYPRESS_ESC;

    always #5 CLK = ~CLK;

    ps2_key_controller #(
        .SYNC_STAGES   (2),
        .FILTER_LEN    (8),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .PS2_CLK       (PS2_CLK),
        .PS2_DAT       (PS2_DAT),
        .RX_DATA       (RX_DATA),
        .RX_VALID      (RX_VALID),
        .RX_ERR        (RX_ERR),
        .SCAN_CODE     (SCAN_CODE),
        .KEY_EVENT     (KEY_EVENT),
        .KEY_BREAK     (KEY_BREAK),
        .KEY_EXT       (KEY_EXT),
        .KEYPRESS_SPACE(KEYPRESS_SPACE),
        .KEYPRESS_W    (KEYPRESS_W),
        .KEYPRESS_S    (KEYPRESS_S),
        .KEYPRESS_ESC  (KEYPRESS_ESC)
    );

    int n_pass = 0;
    int n_total = 0;

    int   n_valid = 0, n_err = 0, n_event = 0, n_overlap = 0, n_lat = 0;
    logic prev_valid = 1'b0;

    always @(negedge CLK) begin
        if (RX_VALID) n_valid++;
        if (RX_ERR) n_err++;
        if (KEY_EVENT) n_event++;
        if (RX_VALID && RX_ERR) n_overlap++;
        if (KEY_EVENT && !prev_valid) n_lat++;
        prev_valid = RX_VALID;
    end

    typedef struct {
        logic [7:0] d;
        bit         bp, bs, gl;
        int         ev_v, ev_e, ev_k;
        logic [7:0] code;
        bit         kb, kx;
        logic [3:0] flags;
        logic [7:0] rxd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic [7:0] d, input bit bp, input bit bs, input bit gl,
                                input int v, input int e, input int k, input logic [7:0] code,
                                input bit kb, input bit kx, input logic [3:0] flags,
                                input logic [7:0] rxd);
        vec_t r;
        r.d = d; r.bp = bp; r.bs = bs; r.gl = gl;
        r.ev_v = v; r.ev_e = e; r.ev_k = k;
        r.code = code; r.kb = kb; r.kx = kx; r.flags = flags; r.rxd = rxd;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic logic [3:0] flags_now();
        return {KEYPRESS_ESC, KEYPRESS_S, KEYPRESS_W, KEYPRESS_SPACE};
    endfunction

    task automatic send_frame(input logic [7:0] d, input bit bp, input bit bs, input bit gl,
                              input int nbits);
        logic [10:0] bits;
        bits = {~bs, (~^d) ^ bp, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            PS2_DAT = bits[i];
            if (gl && i == 4) begin
                cyc(13); PS2_CLK = 1'b0; cyc(2); PS2_CLK = 1'b1; cyc(HP - 15);
            end else begin
                cyc(HP);
            end
            PS2_CLK = 1'b0;
            if (gl && i == 4) begin
                cyc(13); PS2_CLK = 1'b1; cyc(2); PS2_CLK = 1'b0; cyc(HP - 15);
            end else begin
                cyc(HP);
            end
            PS2_CLK = 1'b1;
        end
        PS2_DAT = 1'b1;
        cyc(2 * HP);
    endtask

    task automatic check_outs(input string tag, input int dv, input int de, input int dk,
                              input logic [7:0] code, input bit kb, input bit kx,
                              input logic [3:0] flags, input logic [7:0] rxd);
        chk({tag, " rx_valid_cnt"}, dv, 0 + dv == dv ? dv : 0);
        chk({tag, " rx_err_cnt"}, de, de);
        chk({tag, " key_event_cnt"}, dk, dk);
        chk({tag, " scan_code"}, int'(SCAN_CODE), int'(code));
        chk({tag, " key_break"}, int'(KEY_BREAK), int'(kb));
        chk({tag, " key_ext"}, int'(KEY_EXT), int'(kx));
        chk({tag, " flags"}, int'(flags_now()), int'(flags));
        chk({tag, " rx_data"}, int'(RX_DATA), int'(rxd));
    endtask

    task automatic run_frame(input string tag, input logic [7:0] d, input bit bp, input bit bs,
                             input bit gl, input int ev_v, input int ev_e, input int ev_k,
                             input logic [7:0] code, input bit kb, input bit kx,
                             input logic [3:0] flags, input logic [7:0] rxd);
        int v0, e0, k0;
        v0 = n_valid; e0 = n_err; k0 = n_event;
        send_frame(d, bp, bs, gl, 11);
        chk({tag, " rx_valid_cnt"}, n_valid - v0, ev_v);
        chk({tag, " rx_err_cnt"}, n_err - e0, ev_e);
        chk({tag, " key_event_cnt"}, n_event - k0, ev_k);
        chk({tag, " scan_code"}, int'(SCAN_CODE), int'(code));
        chk({tag, " key_break"}, int'(KEY_BREAK), int'(kb));
        chk({tag, " key_ext"}, int'(KEY_EXT), int'(kx));
        chk({tag, " flags"}, int'(flags_now()), int'(flags));
        chk({tag, " rx_data"}, int'(RX_DATA), int'(rxd));
    endtask

    // Reference decoder state for the randomized phase.
    logic [7:0] m_rxd, m_code;
    bit         m_brk, m_ext, m_kb, m_kx;
    bit         held[256];

    task automatic model_reset();
        m_rxd = 8'h00; m_code = 8'h00;
        m_brk = 0; m_ext = 0; m_kb = 0; m_kx = 0;
        for (int i = 0; i < 256; i++) held[i] = 0;
    endtask

    task automatic model_frame(input string tag, input logic [7:0] d, input bit bp,
                               input bit bs, input bit gl);
        int ev_v, ev_e, ev_k;
        ev_v = 0; ev_e = 0; ev_k = 0;
        if (bp || bs) begin
            ev_e = 1;
            m_brk = 0; m_ext = 0;
        end else begin
            ev_v = 1;
            m_rxd = d;
            if (d == 8'hE0) m_ext = 1;
            else if (d == 8'hF0) m_brk = 1;
            else if (d != 8'h00) begin
                ev_k = 1;
                m_code = d; m_kb = m_brk; m_kx = m_ext;
                if (!m_ext) held[d] = !m_brk;
                m_brk = 0; m_ext = 0;
            end
        end
        run_frame(tag, d, bp, bs, gl, ev_v, ev_e, ev_k, m_code, m_kb, m_kx,
                  {held[8'h76], held[8'h1B], held[8'h1D], held[8'h29]}, m_rxd);
    endtask

    logic [7:0] pool[8];

    initial begin
        int v0, e0;
        logic [7:0] d;
        int r;

        pool = '{8'hE0, 8'hF0, 8'h00, 8'h29, 8'h1D, 8'h1B, 8'h76, 8'h75};
        RST_N = 1'b0; PS2_CLK = 1'b1; PS2_DAT = 1'b1;
        cyc(5);
        chk("reset rx_data", int'(RX_DATA), 0);
        chk("reset pulses", int'({RX_VALID, RX_ERR, KEY_EVENT}), 0);
        chk("reset scan_code", int'(SCAN_CODE), 0);
        chk("reset brk_ext", int'({KEY_BREAK, KEY_EXT}), 0);
        chk("reset flags", int'(flags_now()), 0);
        RST_N = 1'b1;
        cyc(20);

        //            d      bp bs gl  v  e  k  code   kb kx flags    rxd
        tbl.push_back(mk(8'h29, 0, 0, 0, 1, 0, 1, 8'h29, 0, 0, 4'b0001, 8'h29));
        tbl.push_back(mk(8'hF0, 0, 0, 0, 1, 0, 0, 8'h29, 0, 0, 4'b0001, 8'hF0));
        tbl.push_back(mk(8'h29, 0, 0, 0, 1, 0, 1, 8'h29, 1, 0, 4'b0000, 8'h29));
        tbl.push_back(mk(8'hE0, 0, 0, 0, 1, 0, 0, 8'h29, 1, 0, 4'b0000, 8'hE0));
        tbl.push_back(mk(8'hF0, 0, 0, 0, 1, 0, 0, 8'h29, 1, 0, 4'b0000, 8'hF0));
        tbl.push_back(mk(8'h75, 0, 0, 0, 1, 0, 1, 8'h75, 1, 1, 4'b0000, 8'h75));
        tbl.push_back(mk(8'h1D, 0, 0, 0, 1, 0, 1, 8'h1D, 0, 0, 4'b0010, 8'h1D));
        tbl.push_back(mk(8'hE0, 0, 0, 0, 1, 0, 0, 8'h1D, 0, 0, 4'b0010, 8'hE0));
        tbl.push_back(mk(8'h1D, 0, 0, 0, 1, 0, 1, 8'h1D, 0, 1, 4'b0010, 8'h1D));
        tbl.push_back(mk(8'hE0, 0, 0, 0, 1, 0, 0, 8'h1D, 0, 1, 4'b0010, 8'hE0));
        tbl.push_back(mk(8'hF0, 0, 0, 0, 1, 0, 0, 8'h1D, 0, 1, 4'b0010, 8'hF0));
        tbl.push_back(mk(8'h1D, 0, 0, 0, 1, 0, 1, 8'h1D, 1, 1, 4'b0010, 8'h1D));
        tbl.push_back(mk(8'h1B, 1, 0, 0, 0, 1, 0, 8'h1D, 1, 1, 4'b0010, 8'h1D));
        tbl.push_back(mk(8'h1B, 0, 1, 0, 0, 1, 0, 8'h1D, 1, 1, 4'b0010, 8'h1D));
        tbl.push_back(mk(8'hE0, 0, 0, 0, 1, 0, 0, 8'h1D, 1, 1, 4'b0010, 8'hE0));
        tbl.push_back(mk(8'h1B, 1, 0, 0, 0, 1, 0, 8'h1D, 1, 1, 4'b0010, 8'hE0));
        tbl.push_back(mk(8'h1B, 0, 0, 0, 1, 0, 1, 8'h1B, 0, 0, 4'b0110, 8'h1B));
        tbl.push_back(mk(8'h1B, 0, 0, 1, 1, 0, 1, 8'h1B, 0, 0, 4'b0110, 8'h1B));
        tbl.push_back(mk(8'hF0, 0, 0, 0, 1, 0, 0, 8'h1B, 0, 0, 4'b0110, 8'hF0));
        tbl.push_back(mk(8'h1B, 0, 0, 1, 1, 0, 1, 8'h1B, 1, 0, 4'b0010, 8'h1B));
        tbl.push_back(mk(8'h00, 0, 0, 0, 1, 0, 0, 8'h1B, 1, 0, 4'b0010, 8'h00));

        foreach (tbl[i]) begin
            run_frame($sformatf("vec%0d", i), tbl[i].d, tbl[i].bp, tbl[i].bs, tbl[i].gl,
                      tbl[i].ev_v, tbl[i].ev_e, tbl[i].ev_k, tbl[i].code, tbl[i].kb,
                      tbl[i].kx, tbl[i].flags, tbl[i].rxd);
        end

        // Watchdog: start bit plus five data bits, then the clock stays high.
        v0 = n_valid; e0 = n_err;
        send_frame(8'h55, 0, 0, 0, 6);
        cyc(TMO + 100);
        chk("timeout rx_err_cnt", n_err - e0, 1);
        chk("timeout rx_valid_cnt", n_valid - v0, 0);
        chk("timeout rx_data", int'(RX_DATA), 8'h00);
        run_frame("after_timeout", 8'h76, 0, 0, 0, 1, 0, 1, 8'h76, 0, 0, 4'b1010, 8'h76);

        // Reset in the middle of a frame.
        send_frame(8'h1B, 0, 0, 0, 5);
        RST_N = 1'b0;
        cyc(3);
        chk("midreset rx_data", int'(RX_DATA), 0);
        chk("midreset scan_code", int'(SCAN_CODE), 0);
        chk("midreset flags", int'(flags_now()), 0);
        chk("midreset pulses_brk_ext", int'({RX_VALID, RX_ERR, KEY_EVENT, KEY_BREAK, KEY_EXT}), 0);
        RST_N = 1'b1;
        cyc(20);
        model_reset();
        model_frame("post_reset", 8'h29, 0, 0, 0);

        for (int i = 0; i < 30; i++) begin
            if ($urandom_range(0, 9) < 8) d = pool[$urandom_range(0, 7)];
            else d = 8'($urandom());
            r = $urandom_range(0, 9);
            model_frame($sformatf("rand%0d", i), d, r == 0, r == 1, $urandom_range(0, 4) == 0);
        end

        chk("valid_err_overlap", n_overlap, 0);
        chk("event_latency", n_lat, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
